csr_access_unit: RTL

Execute-stage initiator for the CSR register bank. Accepts one Zicsr instruction at a time from the pipeline and drives the bank's read port (`raddr`/`rdata`). It computes the read-modify-write value, drives the bank's write port (`wen`/`waddr`/`wdata`), and returns the old CSR value for write-back to `rd`. It sits between the EX stage and the CSR register bank, and is the only writer of that bank.

---
 rtl/csr_access_unit_if.sv | 41 ++++
 rtl/csr_access_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/csr_access_unit_if.sv
// Request/response/bank bundle between the EX stage, csr_access_unit and the CSR bank.
// slave: the access unit's view (takes requests, drives the bank ports and responses).
// master: the environment's view (pipeline + bank + response consumer).
interface csr_access_unit_if;
    // request from EX
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rd;
    logic        flush;
    // CSR bank read/write ports
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    // response to write-back
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_illegal;
    logic        busy;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data, req_rd, flush,
        input  csr_rdata, rsp_ready,
        output req_ready, csr_raddr, csr_wen, csr_waddr, csr_wdata,
        output rsp_valid, rsp_data, rsp_rd, rsp_illegal, busy
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data, req_rd, flush,
        output csr_rdata, rsp_ready,
        input  req_ready, csr_raddr, csr_wen, csr_waddr, csr_wdata,
        input  rsp_valid, rsp_data, rsp_rd, rsp_illegal, busy
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr execute unit: reads a counter CSR, applies RW/RS/RC, writes it back, returns the old value.
// Latency from acceptance: illegal 1 cycle, read-only 2 cycles, read-modify-write 3 cycles.
// One instruction in flight; req_ready only in IDLE; response held until rsp_ready; flush aborts in READ.
// Ports: clk, rst (sync, active high), bus (csr_access_unit_if.slave: req_*, flush, csr_*, rsp_*, busy).
module csr_access_unit #(
    parameter bit ALLOW_WRITE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    csr_access_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic [1:0]  op_q;        // funct3[1:0]: 01 RW, 10 RS, 11 RC
    logic [4:0]  rs1_idx_q;
    logic [31:0] operand_q;
    logic [31:0] old_val;
    logic        ready_q;
    logic        wen_q;

    logic        addr_legal;
    logic        req_writes;
    logic        req_illegal;
    logic [31:0] req_operand;
    logic        req_ready_int;
    logic        req_fire;
    logic        write_needed;
    logic [31:0] new_val;

    always_comb begin
        addr_legal = 1'b0;
        case (bus.req_addr)
            12'hC00, 12'hC80, 12'hC02, 12'hC82: addr_legal = 1'b1;
            default:                            addr_legal = 1'b0;
        endcase
    end

    // Set/clear forms with rs1/zimm == 0 are pure reads.
    assign req_writes    = (bus.req_funct3[1:0] == 2'b01) || (bus.req_rs1_idx != 5'd0);
    assign req_illegal   = !addr_legal || (bus.req_funct3[1:0] == 2'b00) || (!ALLOW_WRITE && req_writes);
    assign req_operand   = bus.req_funct3[2] ? {27'd0, bus.req_rs1_idx} : bus.req_rs1_data;

    assign req_ready_int = ready_q && !bus.flush && !rst;
    assign req_fire      = bus.req_valid && req_ready_int;
    assign bus.req_ready = req_ready_int;

    // A write cycle caught by reset must not reach the bank.
    assign bus.csr_wen   = wen_q && !rst;

    assign write_needed  = (op_q == 2'b01) || (rs1_idx_q != 5'd0);

    // Computed from the bank data seen in READ (the same value captured into old_val),
    // so csr_wdata can be registered and presented throughout the WRITE cycle.
    always_comb begin
        new_val = operand_q;
        case (op_q)
            2'b10:   new_val = bus.csr_rdata | operand_q;
            2'b11:   new_val = bus.csr_rdata & ~operand_q;
            default: new_val = operand_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            op_q            <= 2'b00;
            rs1_idx_q       <= 5'd0;
            operand_q       <= 32'd0;
            old_val         <= 32'd0;
            ready_q         <= 1'b0;
            wen_q           <= 1'b0;
            bus.csr_raddr   <= 12'd0;
            bus.csr_waddr   <= 12'd0;
            bus.csr_wdata   <= 32'd0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= 32'd0;
            bus.rsp_rd      <= 5'd0;
            bus.rsp_illegal <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_fire) begin
                        op_q            <= bus.req_funct3[1:0];
                        rs1_idx_q       <= bus.req_rs1_idx;
                        operand_q       <= req_operand;
                        bus.csr_raddr   <= bus.req_addr;
                        bus.rsp_rd      <= bus.req_rd;
                        bus.rsp_illegal <= req_illegal;
                        bus.rsp_data    <= 32'd0;
                        ready_q         <= 1'b0;
                        bus.busy        <= 1'b1;
                        if (req_illegal) begin
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            state         <= READ;
                        end
                    end
                end
                READ: begin
                    if (bus.flush) begin
                        ready_q  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        old_val <= bus.csr_rdata;
                        if (write_needed) begin
                            wen_q         <= 1'b1;
                            bus.csr_waddr <= bus.csr_raddr;
                            bus.csr_wdata <= new_val;
                            state         <= WRITE;
                        end else begin
                            bus.rsp_data  <= bus.csr_rdata;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                WRITE: begin
                    wen_q         <= 1'b0;
                    bus.rsp_data  <= old_val;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        ready_q       <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
